// File: rtl/repetition_decoder_if.sv
// Serial hard-bit input and parallel decoded-block output
// bundle for the repetition decoder.
interface repetition_decoder_if #(
    parameter int N_BITS = 16
);
    logic              in_en;
    logic              d_in;
    logic [0:N_BITS-1] y;
    logic              out_done;
    logic              all_agree;

    modport master (
        output in_en,
        output d_in,
        input  y,
        input  out_done,
        input  all_agree
    );

    modport slave (
        input  in_en,
        input  d_in,
        output y,
        output out_done,
        output all_agree
    );
endinterface

// File: rtl/repetition_decoder.sv
// Majority-combines REP serial copies of an N_BITS block
// into a parallel word with a one-cycle done strobe.
module repetition_decoder #(
    parameter int N_BITS = 16,
    parameter int REP    = 3
) (
    input logic                 clk,
    input logic                 reset,
    repetition_decoder_if.slave bus
);
    localparam int CW = $clog2(REP + 1);
    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int RW = (REP > 1) ? $clog2(REP) : 1;

    localparam logic [CW-1:0] HALF     = CW'(REP / 2);
    localparam logic [CW-1:0] FULL     = CW'(REP);
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);

    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [RW-1:0]     rep_idx_q, rep_idx_d;
    logic [CW-1:0]     ones_q [N_BITS];
    logic [CW-1:0]     ones_d [N_BITS];
    logic [CW-1:0]     cnt    [N_BITS];
    logic [0:N_BITS-1] y_q, y_d;
    logic [0:N_BITS-1] dec;
    logic [0:N_BITS-1] unan;
    logic              done_q, done_d;
    logic              agree_q, agree_d;
    logic              last;

    always_comb begin
        last = bus.in_en
            && (bit_idx_q == BIT_LAST)
            && (rep_idx_q == REP_LAST);

        // cnt includes the sample accepted on this edge, so the
        // final decision sees it without an extra cycle
        for (int b = 0; b < N_BITS; b++) begin
            cnt[b] = ones_q[b];
            if (bus.in_en && (bit_idx_q == BW'(b)))
                cnt[b] = ones_q[b] + CW'(bus.d_in);
            dec[b]    = cnt[b] > HALF;
            unan[b]   = (cnt[b] == '0) || (cnt[b] == FULL);
            ones_d[b] = last ? '0 : cnt[b];
        end

        bit_idx_d = bit_idx_q;
        rep_idx_d = rep_idx_q;
        if (bus.in_en) begin
            if (bit_idx_q == BIT_LAST) begin
                bit_idx_d = '0;
                if (rep_idx_q == REP_LAST)
                    rep_idx_d = '0;
                else
                    rep_idx_d = rep_idx_q + 1'b1;
            end else begin
                bit_idx_d = bit_idx_q + 1'b1;
            end
        end

        y_d     = last ? dec : y_q;
        agree_d = last ? (&unan) : agree_q;
        done_d  = last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx_q <= '0;
            rep_idx_q <= '0;
            ones_q    <= '{default: '0};
            y_q       <= '0;
            done_q    <= 1'b0;
            agree_q   <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            rep_idx_q <= rep_idx_d;
            ones_q    <= ones_d;
            y_q       <= y_d;
            done_q    <= done_d;
            agree_q   <= agree_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.out_done  = done_q;
    assign bus.all_agree = agree_q;
endmodule
